// File: rtl/mmio_port_unit_if.sv
// Data-memory bus bundle seen by the MMIO unit.
// The master is the core/top level; the slave is the I/O block.
interface mmio_port_unit_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_port_unit.sv
// MMIO window: PORT_OUT, synchronised PORT_IN, W1C STATUS, countdown TIMER.
// Define MMIO_TIMER_AUTORELOAD_EN for a periodic timer (else one-shot).
module mmio_port_unit #(
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  mmio_port_unit_if.slave   bus,
  input  logic [7:0]        PortIn,
  output logic [31:0]       PortOut,
  output logic              TimerIrq
);

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_TMR  = 2'd3;

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_RUN  = 1'b1;

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0]  in_prev_q, in_prev_d;
  logic [31:0] port_out_q, port_out_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;

  logic [7:0]  in_sync;
  logic [1:0]  off;
  logic        hit;
  logic        we;
  logic        timer_wr;
  logic        expire;
  logic [0:0]  t_state;
  logic [1:0]  w1c;
  logic [31:0] rdata;
  logic        unused_addr;

  assign unused_addr = ^bus.Address[1:0];

  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign off      = bus.Address[3:2];
  assign hit      = (bus.Address[31:4] == IO_BASE[31:4]);
  assign we       = bus.MemWrite & hit;
  assign timer_wr = we & (off == OFF_TMR);
  assign t_state  = (count_q != '0) ? T_RUN : T_IDLE;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], PortIn};
    in_prev_d = in_sync;
    port_out_d = port_out_q;
    if (we && off == OFF_OUT) port_out_d = bus.WriteData;
  end

  // Set events win over a same-cycle write-one-to-clear.
  always_comb begin
    w1c = '0;
    if (we && off == OFF_STAT) w1c = bus.WriteData[1:0];
    status_d = (status_q & ~w1c)
             | {expire, (in_sync != in_prev_q)};
  end

  always_comb begin
    expire   = 1'b0;
    count_d  = count_q;
    reload_d = reload_q;
    unique case (t_state)
      T_IDLE: count_d = count_q;
      T_RUN: begin
        if (count_q == 32'd1) begin
          expire = 1'b1;
`ifdef MMIO_TIMER_AUTORELOAD_EN
          count_d = reload_q;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      default: count_d = count_q;
    endcase
    // A bus write still overrides the reload on an expiry edge.
    if (timer_wr) begin
      count_d  = bus.WriteData;
      reload_d = bus.WriteData;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_OUT:  rdata = port_out_q;
      OFF_IN:   rdata = {24'b0, in_sync};
      OFF_STAT: rdata = {30'b0, status_q};
      OFF_TMR:  rdata = count_q;
      default:  rdata = '0;
    endcase
  end

  assign bus.Hit      = hit;
  assign bus.ReadData = (bus.MemRead & hit) ? rdata : '0;
  assign PortOut      = port_out_q;
  assign TimerIrq     = status_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      in_prev_q  <= '0;
      port_out_q <= '0;
      status_q   <= '0;
      count_q    <= '0;
      reload_q   <= '0;
    end else begin
      sync_q     <= sync_d;
      in_prev_q  <= in_prev_d;
      port_out_q <= port_out_d;
      status_q   <= status_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
    end
  end

endmodule

// File: tb/tb_mmio_port_unit.sv
// Directed bench for mmio_port_unit: vector table plus
// hand-written pin, timer and reset sequences.
module tb_mmio_port_unit;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [7:0]  port_in;
  logic [31:0] port_out;
  logic        timer_irq;
  int          n_tests;
  int          n_fail;

  mmio_port_unit_if bus();

  mmio_port_unit #(.IO_BASE(BASE), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .PortIn   (port_in),
    .PortOut  (port_out),
    .TimerIrq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [31:0] exp_port;
    string       name;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input string name);
    bus.Address  = a;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    #1;
    chk(name, bus.ReadData, exp);
    bus.MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    port_in = 8'h00;
    bus.Address   = BASE;
    bus.WriteData = '0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;

    vt[0]  = '{0, 1, BASE+32'h0,  32'h0, 32'h0, 1, 32'h0, "rst_out"};
    vt[1]  = '{0, 1, BASE+32'h4,  32'h0, 32'h0, 1, 32'h0, "rst_in"};
    vt[2]  = '{0, 1, BASE+32'h8,  32'h0, 32'h0, 1, 32'h0, "rst_stat"};
    vt[3]  = '{0, 1, BASE+32'hC,  32'h0, 32'h0, 1, 32'h0, "rst_tmr"};
    vt[4]  = '{1, 0, BASE+32'h0,  32'hDEAD_BEEF, 32'h0, 1,
               32'hDEAD_BEEF, "wr_out"};
    vt[5]  = '{0, 1, BASE+32'h0,  32'h0, 32'hDEAD_BEEF, 1,
               32'hDEAD_BEEF, "rd_out"};
    vt[6]  = '{1, 0, BASE+32'h10, 32'h1234_5678, 32'h0, 0,
               32'hDEAD_BEEF, "wr_miss"};
    vt[7]  = '{0, 1, BASE+32'h10, 32'h0, 32'h0, 0,
               32'hDEAD_BEEF, "rd_miss"};
    vt[8]  = '{0, 1, BASE+32'h3,  32'h0, 32'hDEAD_BEEF, 1,
               32'hDEAD_BEEF, "rd_byteoff"};
    vt[9]  = '{1, 0, BASE+32'h4,  32'hFFFF_FFFF, 32'h0, 1,
               32'hDEAD_BEEF, "wr_in_ro"};
    vt[10] = '{0, 1, BASE+32'h4,  32'h0, 32'h0, 1,
               32'hDEAD_BEEF, "rd_in_ro"};
    vt[11] = '{0, 0, BASE+32'h0,  32'h0, 32'h0, 1,
               32'hDEAD_BEEF, "no_rd_strobe"};
    vt[12] = '{1, 0, BASE+32'h0,  32'h0000_1234, 32'h0, 1,
               32'h0000_1234, "wr_out2"};
    vt[13] = '{0, 1, 32'hFFFE_0000, 32'h0, 32'h0, 0,
               32'h0000_1234, "rd_far"};

    tick(2);
    reset = 1'b0;
    chk("rst_portout", port_out, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      bus.Address   = vt[i].addr;
      bus.WriteData = vt[i].wdata;
      bus.MemWrite  = vt[i].wr;
      bus.MemRead   = vt[i].rd;
      #1;
      chk({vt[i].name, "_hit"}, {31'b0, bus.Hit},
          {31'b0, vt[i].exp_hit});
      chk({vt[i].name, "_rdata"}, bus.ReadData, vt[i].exp_rd);
      if (vt[i].wr) begin
        @(posedge clk);
        @(negedge clk);
      end
      bus.MemWrite = 1'b0;
      bus.MemRead  = 1'b0;
      chk({vt[i].name, "_port"}, port_out, vt[i].exp_port);
    end

    // Pin synchronisation and change detection
    port_in = 8'hA5;
    tick(1);
    rd(BASE+32'h4, 32'h0, "in_1edge");
    tick(1);
    rd(BASE+32'h4, 32'hA5, "in_2edge");
    rd(BASE+32'h8, 32'h0, "chg_2edge");
    tick(1);
    rd(BASE+32'h8, 32'h1, "chg_3edge");
    wr(BASE+32'h8, 32'h1);
    rd(BASE+32'h8, 32'h0, "chg_w1c");
    port_in = 8'h5A;
    tick(2);
    rd(BASE+32'h8, 32'h0, "chg_pre");
    wr(BASE+32'h8, 32'h1);
    rd(BASE+32'h8, 32'h1, "chg_set_wins");
    wr(BASE+32'h8, 32'h1);
    rd(BASE+32'h8, 32'h0, "chg_clr2");

    // Timer countdown and expiry
    wr(BASE+32'hC, 32'd5);
    rd(BASE+32'hC, 32'd5, "tmr_load");
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      rd(BASE+32'hC, 32'd5 - k, $sformatf("tmr_cnt%0d", k));
      chk($sformatf("tmr_irq_lo%0d", k), {31'b0, timer_irq}, 32'h0);
    end
    tick(1);
    chk("tmr_irq_hi", {31'b0, timer_irq}, 32'h1);
    rd(BASE+32'h8, 32'h2, "tmr_stat");
`ifdef MMIO_TIMER_AUTORELOAD_EN
    rd(BASE+32'hC, 32'd5, "tmr_reload");
`else
    rd(BASE+32'hC, 32'd0, "tmr_oneshot");
    tick(1);
    rd(BASE+32'hC, 32'd0, "tmr_hold0");
`endif
    wr(BASE+32'hC, 32'd0);
    wr(BASE+32'h8, 32'h2);
    rd(BASE+32'h8, 32'h0, "tmr_stat_clr");
    rd(BASE+32'hC, 32'd0, "tmr_stopped");
    chk("tmr_irq_clr", {31'b0, timer_irq}, 32'h0);

    // Timer rewrite on the expiry edge
    wr(BASE+32'hC, 32'd3);
    tick(2);
    rd(BASE+32'hC, 32'd1, "tmr3_at1");
    wr(BASE+32'hC, 32'd7);
    rd(BASE+32'hC, 32'd7, "tmr_rewrite");
    rd(BASE+32'h8, 32'h2, "tmr_rewrite_exp");
    chk("tmr_rewrite_irq", {31'b0, timer_irq}, 32'h1);

    // Reset mid-operation with a concurrent store
    port_in = 8'hFF;
    tick(3);
    rd(BASE+32'h8, 32'h3, "pre_rst_stat");
    rd(BASE+32'hC, 32'd4, "pre_rst_cnt");
    reset         = 1'b1;
    bus.Address   = BASE;
    bus.WriteData = 32'hFFFF_FFFF;
    bus.MemWrite  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset        = 1'b0;
    bus.MemWrite = 1'b0;
    rd(BASE+32'h0, 32'h0, "mid_rst_out");
    rd(BASE+32'h4, 32'h0, "mid_rst_in");
    rd(BASE+32'h8, 32'h0, "mid_rst_stat");
    rd(BASE+32'hC, 32'h0, "mid_rst_tmr");
    chk("mid_rst_port", port_out, 32'h0);
    chk("mid_rst_irq", {31'b0, timer_irq}, 32'h0);
    tick(1);
    rd(BASE+32'h8, 32'h0, "post_rst_stat");
    rd(BASE+32'hC, 32'h0, "post_rst_tmr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_port_unit.md
# mmio_port_unit

Memory-mapped I/O unit on the processor's data-memory bus, in parallel with the data memory. It decodes a 16-byte I/O window, returns read data combinationally within the same cycle, and drives the top-level `PortOut` register. It synchronises the 8-bit `PortIn` pins, latches input-change and timer-expiry events into sticky status bits, and runs a countdown timer. The top level selects this block's `ReadData` when `Hit` is high and gates `MemWrite` to the data memory with `!Hit`.

## Interface
- `IO_BASE`, 32'hFFFF_0000, base byte address of the window; bits [3:0] ignored.
- `SYNC_STAGES`, 2, number of `PortIn` synchroniser flops, minimum 2.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high. All state clears on the rising edge while high.
- `Address` input 32: byte address from the ALU result.
- `WriteData` input 32: store data (rt register value).
- `MemWrite` input 1: store strobe.
- `MemRead` input 1: load strobe.
- `ReadData` output 32: load data. Combinational; 0 unless `MemRead & Hit`.
- `Hit` output 1: combinational, `Address[31:4] == IO_BASE[31:4]`.
- `PortIn` input 8: asynchronous pins.
- `PortOut` output 32: PORT_OUT register; reset 0.
- `TimerIrq` output 1: equals STATUS[1]; reset 0.

## Operation
- Word offset is `Address[3:2]`. `Address[1:0]` is ignored, so all accesses are word accesses.
- Writes commit on the rising edge when `MemWrite & Hit`. Reads have no side effects.
- 0x0 PORT_OUT (R/W): write loads all 32 bits; read returns the value.
- 0x4 PORT_IN (RO): read returns `{24'b0, in_sync}`. Writes are ignored.
- 0x8 STATUS (R/W1C): bit0 IN_CHANGED, bit1 TIMER_EXPIRED, bits[31:2] read 0. Writing 1 to a bit clears it.
- 0xC TIMER (R/W): a write loads both `count` and `reload` with `WriteData`. A write of 0 stops the timer. A read returns the current `count`.
- Input path: `PortIn` passes through SYNC_STAGES flops to produce `in_sync`, then one more register produces `in_prev`. IN_CHANGED sets on any edge where `in_sync != in_prev`.
- Timer has two states, IDLE (`count==0`) and RUN (`count!=0`).
  - In RUN, `count` decrements by 1 every cycle.
  - On the edge where `count==1`, TIMER_EXPIRED sets and the next state follows the Configuration section.
  - Arithmetic is 32-bit unsigned; `count` never wraps below 0.
- Simultaneous events:
  - A set event and a W1C on the same bit in the same cycle: set wins, so the bit stays 1.
  - A TIMER write and expiry (`count==1`) in the same cycle: the written value loads `count`, and TIMER_EXPIRED still sets.
  - A write with `Hit` low has no effect on this block.
- Reset mid-operation: `count`, `reload`, PORT_OUT, STATUS, and all synchroniser/prev flops clear to 0 on the edge, regardless of bus activity in that cycle. No change event is generated by reset.

## Timing
- Read latency is 0 cycles: `ReadData` is valid in the same cycle as `Address`/`MemRead`, as the single-cycle datapath requires.
- Write latency is 1 edge: the new value is visible to reads and on `PortOut` in the following cycle.
- PortIn-to-PORT_IN latency is SYNC_STAGES edges. IN_CHANGED sets at edge SYNC_STAGES+1 after the pin change.
- Timer: a write of N≥1 at edge E gives `count==N-k` after edge E+k. TIMER_EXPIRED and `TimerIrq` are high after edge E+N.

## Configuration
- `MMIO_TIMER_AUTORELOAD_EN` defined: on expiry, `count` loads `reload`. The timer is periodic with period N cycles and stays in RUN while `reload!=0`.
- Not defined: on expiry, `count` goes to 0 and the timer stays in IDLE (one-shot). `reload` is still stored but is not used for reloading.

## Test plan
- Reset, then read 0x0, 0x4, 0x8, 0xC at IO_BASE. Expected: all return 0, `PortOut==0`, `TimerIrq==0`, `Hit==1`.
- Store 32'hDEAD_BEEF to IO_BASE+0x0, then load it. Expected: `PortOut==32'hDEAD_BEEF` next cycle, load returns the same. A store to IO_BASE+0x10 gives `Hit==0` and leaves `PortOut` unchanged.
- Drive `PortIn=8'hA5`. Expected: PORT_IN reads 32'h0000_00A5 after 2 edges; STATUS reads 1 after 3 edges. Write 1 to STATUS: expected 0. Then clear in the same cycle as a new pin change: expected bit0 stays 1.
- Write TIMER=5. Expected: reads return 4,3,2,1 on successive cycles; `TimerIrq` rises after edge 5; count then holds 0 with the macro undefined, or shows 5 again with the macro defined.
- Write TIMER=3, then write 7 on the cycle where `count==1`. Expected: count becomes 7 and TIMER_EXPIRED sets.
- Assert `reset` for one cycle while the timer is running and IN_CHANGED is set. Expected: all registers read 0 on the next cycle, with no spurious IN_CHANGED.
